// File: rtl/hm32_if.sv
// hm32 operand/result bundle: start/mode/operands in, busy/done/product out.
// No latency of its own; it only groups the wires.
// No backpressure: the requester watches busy/done; a start during busy is dropped.
interface hm32_if #(
    parameter int InputWidth  = 32,
    parameter int OutputWidth = 64
);
    logic                   start;
    logic                   mode;
    logic [InputWidth-1:0]  multiplicand;
    logic [InputWidth-1:0]  multiplier;
    logic                   busy;
    logic                   done;
    logic [OutputWidth-1:0] product;

    // Requester side: drives the request, observes the result
    modport master (
        output start, mode, multiplicand, multiplier,
        input  busy, done, product
    );

    // Multiplier side: consumes the request, produces the result
    modport slave (
        input  start, mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/hm32.sv
// Sequential 32x32 -> 64 radix-2 shift-add multiplier, unsigned or two's-complement signed.
// Fixed latency: done pulses 33 edges after the edge that accepts start.
// No queuing: start is only sampled in IDLE; requests and operand changes during busy are ignored.
module hm32 #(
    parameter int InputWidth  = 32,
    parameter int OutputWidth = 64
) (
    input  logic clk,
    input  logic rst_n,
    hm32_if.slave bus
);
    localparam int CntW = $clog2(InputWidth);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;

    localparam logic [InputWidth-1:0]  OneIn  = 1;
    localparam logic [OutputWidth-1:0] OneOut = 1;
    localparam logic [CntW-1:0]        LastIt = CntW'(InputWidth - 1);

    logic [1:0]             state;
    logic [CntW-1:0]        cnt;
    logic [InputWidth-1:0]  mag_a;
    logic [InputWidth-1:0]  mag_b;
    logic [OutputWidth-1:0] acc;
    logic                   neg;
    logic                   busy_q;
    logic                   done_q;
    logic [OutputWidth-1:0] product_q;

    logic                   a_neg;
    logic                   b_neg;
    logic [OutputWidth-1:0] addend;

    // Operand sign detection and the shifted partial product for this iteration
    always_comb begin
        a_neg  = bus.mode & bus.multiplicand[InputWidth-1];
        b_neg  = bus.mode & bus.multiplier[InputWidth-1];
        addend = OutputWidth'(mag_a) << cnt;
    end

    // Control FSM plus datapath: capture magnitudes, 32 shift-add steps, then sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // 0x80000000 negates to itself, which is the correct unsigned magnitude
                        mag_a  <= a_neg ? (~bus.multiplicand + OneIn) : bus.multiplicand;
                        mag_b  <= b_neg ? (~bus.multiplier + OneIn) : bus.multiplier;
                        neg    <= a_neg ^ b_neg;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Unsigned magnitudes cannot overflow 64 bits, so no carry-out is kept
                    if (mag_b[0]) begin
                        acc <= acc + addend;
                    end
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LastIt) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    // Negating a zero magnitude gives zero, so there is no negative zero
                    product_q <= neg ? (~acc + OneOut) : acc;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule
